// File: rtl/mxv_pkg.sv
// mxv_pkg: shared state encoding, default widths and ceil-divide helper for the row sequencer
package mxv_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT_RES, WRITE, FINISH} state_t;
  localparam int def_element_width = 32;
  localparam int def_no_of_units = 8;
  localparam int def_addr_width = 16;
  function automatic logic [31:0] ceil_div(input logic [31:0] n, input logic [31:0] d);
    return n / d + 32'((n % d) != 0);
  endfunction
endpackage

// File: rtl/mxv_row_sequencer_if.sv
// mxv_row_sequencer_if: solver handshake, operand-memory reads, dot-product link and AP write port
interface mxv_row_sequencer_if
  import mxv_pkg::*;
#(
  parameter int element_width = def_element_width,
  parameter int addr_width = def_addr_width
);
  logic start;
  logic [31:0] total;
  logic [addr_width-1:0] no_of_rows;
  logic outsider_read_now;
  logic mat_rd_en;
  logic [addr_width-1:0] mat_rd_addr;
  logic vec_rd_en;
  logic [addr_width-1:0] vec_rd_addr;
  logic dp_in_valid;
  logic dp_last;
  logic [element_width-1:0] dp_result;
  logic dp_result_valid;
  logic AP_total_mem_we;
  logic [addr_width-1:0] ap_addr;
  logic [element_width-1:0] ap_data;
  logic busy;
  logic done;
  modport master (
    input start, total, no_of_rows, outsider_read_now, dp_result, dp_result_valid,
    output mat_rd_en, mat_rd_addr, vec_rd_en, vec_rd_addr, dp_in_valid, dp_last,
    output AP_total_mem_we, ap_addr, ap_data, busy, done
  );
  modport slave (
    output start, total, no_of_rows, outsider_read_now, dp_result, dp_result_valid,
    input mat_rd_en, mat_rd_addr, vec_rd_en, vec_rd_addr, dp_in_valid, dp_last,
    input AP_total_mem_we, ap_addr, ap_data, busy, done
  );
endinterface

// File: rtl/mxv_chunk_addr_gen.sv
// mxv_chunk_addr_gen: row/chunk counters with a running row base so chunk addresses need no multiplier
module mxv_chunk_addr_gen #(
  parameter int addr_width = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  chunk_inc_i,
  input  logic                  row_inc_i,
  input  logic [addr_width-1:0] cpr_i,
  output logic [addr_width-1:0] row_o,
  output logic [addr_width-1:0] chunk_o,
  output logic [addr_width-1:0] addr_o,
  output logic                  last_chunk_o
);
  logic [addr_width-1:0] row_q, chunk_q, base_q;
  // advance the chunk on each issued read; a new row restarts the chunk and steps the base by one row
  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      row_q <= '0;
      chunk_q <= '0;
      base_q <= '0;
    end else if (row_inc_i) begin
      row_q <= row_q + addr_width'(1);
      chunk_q <= '0;
      base_q <= base_q + cpr_i;
    end else if (chunk_inc_i) begin
      chunk_q <= chunk_q + addr_width'(1);
    end
  end
  assign row_o = row_q;
  assign chunk_o = chunk_q;
  assign addr_o = base_q + chunk_q;
  assign last_chunk_o = chunk_q == cpr_i - addr_width'(1);
endmodule

// File: rtl/mxv_row_sequencer.sv
// mxv_row_sequencer: walks a matrix row by row through the dot-product unit and stores each result
module mxv_row_sequencer
  import mxv_pkg::*;
#(
  parameter int element_width = def_element_width,
  parameter int no_of_units = def_no_of_units,
  parameter int addr_width = def_addr_width
) (
  input logic clk,
  input logic reset,
  mxv_row_sequencer_if.master bus
);
  state_t state_q, state_d;
  logic [addr_width-1:0] cpr_q, rows_q, ap_addr_q, row, chunk, addr;
  logic [element_width-1:0] res_q;
  logic busy_q, done_q, we_q, dp_in_valid_q, dp_last_q;
  logic last_chunk, accept, issue, last_row;
  assign accept = state_q == IDLE && !busy_q && bus.start;
  assign issue = state_q == FETCH && bus.outsider_read_now;
  assign last_row = row == rows_q - addr_width'(1);
  mxv_chunk_addr_gen #(.addr_width(addr_width)) u_addr (
    .clk(clk),
    .reset(reset),
    .clear_i(accept),
    .chunk_inc_i(issue),
    .row_inc_i(state_q == WRITE && !last_row),
    .cpr_i(cpr_q),
    .row_o(row),
    .chunk_o(chunk),
    .addr_o(addr),
    .last_chunk_o(last_chunk)
  );
  // next-state: empty jobs skip straight to FINISH, rows loop FETCH -> WAIT_RES -> WRITE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (accept) state_d = (bus.total == 0 || bus.no_of_rows == 0) ? FINISH : FETCH;
      FETCH:    if (issue && last_chunk) state_d = WAIT_RES;
      WAIT_RES: if (bus.dp_result_valid) state_d = WRITE;
      WRITE:    state_d = last_row ? FINISH : FETCH;
      FINISH:   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end
  // state, job parameters, captured result and the registered write/done/operand-valid outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cpr_q <= '0;
      rows_q <= '0;
      ap_addr_q <= '0;
      res_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      we_q <= 1'b0;
      dp_in_valid_q <= 1'b0;
      dp_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cpr_q <= addr_width'(ceil_div(bus.total, 32'(no_of_units)));
        rows_q <= bus.no_of_rows;
      end
      if (state_q == WRITE) ap_addr_q <= row;
      if (state_q == WAIT_RES && bus.dp_result_valid) res_q <= bus.dp_result;
      busy_q <= accept || (busy_q && !done_q);
      done_q <= state_q == FINISH;
      we_q <= state_q == WRITE;
      dp_in_valid_q <= issue;
      dp_last_q <= issue && last_chunk;
    end
  end
  assign bus.mat_rd_en = issue;
  assign bus.vec_rd_en = issue;
  assign bus.mat_rd_addr = addr;
  assign bus.vec_rd_addr = chunk;
  assign bus.dp_in_valid = dp_in_valid_q;
  assign bus.dp_last = dp_last_q;
  assign bus.AP_total_mem_we = we_q;
  assign bus.ap_addr = ap_addr_q;
  assign bus.ap_data = res_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
endmodule

// File: tb/tb_mxv_row_sequencer.sv
// tb_mxv_row_sequencer: directed vector table plus reset/abort sequences for the row sequencer
module tb_mxv_row_sequencer;
  import mxv_pkg::*;
  localparam int ew = 32;
  localparam int aw = 16;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  mxv_row_sequencer_if #(.element_width(ew), .addr_width(aw)) bus();
  mxv_row_sequencer #(.element_width(ew), .no_of_units(8), .addr_width(aw)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  typedef struct {
    int total;
    int rows;
    logic [31:0] stall_m;
    logic [31:0] start_m;
    logic [31:0] spur_m;
    int n_rd;
    int mat[4];
    int vec[4];
    int rd_cyc[4];
    int last_m;
    int n_wr;
    int done_c;
  } vec_t;
  vec_t vt[7];
  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic logic all_zero();
    return {bus.mat_rd_en, bus.mat_rd_addr, bus.vec_rd_en, bus.vec_rd_addr, bus.dp_in_valid,
            bus.dp_last, bus.AP_total_mem_we, bus.ap_addr, bus.ap_data, bus.busy, bus.done} == '0;
  endfunction
  task automatic run(input vec_t v, input string tag);
    int c = 0, cd = 0, k = 0, done_c = -1, n_done = 0, lm = 0;
    int mq[$], vq[$], cq[$], wa[$];
    logic lq[$];
    logic [31:0] wd[$];
    logic en_bad = 1'b0, busy_bad = 1'b0, resp, spur;
    @(negedge clk);
    bus.start = 1'b1;
    bus.total = v.total;
    bus.no_of_rows = aw'(v.rows);
    bus.outsider_read_now = 1'b1;
    bus.dp_result_valid = 1'b0;
    while (c < 80 && (done_c < 0 || c < done_c + 3)) begin
      @(negedge clk);
      c++;
      bus.start = c < 32 && v.start_m[c[4:0]];
      bus.outsider_read_now = !(c < 32 && v.stall_m[c[4:0]]);
      resp = 1'b0;
      if (cd > 0) begin
        cd--;
        resp = cd == 0;
      end
      spur = c < 32 && v.spur_m[c[4:0]];
      bus.dp_result_valid = resp || spur;
      bus.dp_result = (spur && !resp) ? 32'hDEAD_BEEF : 32'(32'h1000 * (k + 1) + v.total);
      if (resp) k++;
      #1;
      if (bus.vec_rd_en !== bus.mat_rd_en) en_bad = 1'b1;
      if (bus.mat_rd_en) begin
        mq.push_back(int'(bus.mat_rd_addr));
        vq.push_back(int'(bus.vec_rd_addr));
        cq.push_back(c);
      end
      if (bus.dp_in_valid) lq.push_back(bus.dp_last);
      if (bus.dp_in_valid && bus.dp_last) cd = 3;
      if (bus.AP_total_mem_we) begin
        wa.push_back(int'(bus.ap_addr));
        wd.push_back(bus.ap_data);
      end
      if (bus.done) begin
        n_done++;
        if (done_c < 0) done_c = c;
      end
      if (bus.busy !== (done_c < 0 || c == done_c)) busy_bad = 1'b1;
    end
    bus.start = 1'b0;
    bus.dp_result_valid = 1'b0;
    chk({tag, " done_cycle"}, done_c, v.done_c);
    chk({tag, " done_pulses"}, n_done, 1);
    chk({tag, " busy_window"}, busy_bad, 0);
    chk({tag, " rd_en_match"}, en_bad, 0);
    chk({tag, " n_reads"}, mq.size(), v.n_rd);
    for (int i = 0; i < v.n_rd; i++) begin
      chk($sformatf("%s mat_addr[%0d]", tag, i), i < mq.size() ? mq[i] : -1, v.mat[i]);
      chk($sformatf("%s vec_addr[%0d]", tag, i), i < vq.size() ? vq[i] : -1, v.vec[i]);
      chk($sformatf("%s rd_cycle[%0d]", tag, i), i < cq.size() ? cq[i] : -1, v.rd_cyc[i]);
    end
    for (int i = 0; i < lq.size() && i < 31; i++) lm |= int'(lq[i]) << i;
    chk({tag, " dp_valid_count"}, lq.size(), v.n_rd);
    chk({tag, " dp_last_mask"}, lm, v.last_m);
    chk({tag, " n_writes"}, wa.size(), v.n_wr);
    for (int i = 0; i < v.n_wr; i++) begin
      chk($sformatf("%s ap_addr[%0d]", tag, i), i < wa.size() ? wa[i] : -1, i);
      chk($sformatf("%s ap_data[%0d]", tag, i), i < wd.size() ? wd[i] : 32'hFFFF_FFFF,
          32'(32'h1000 * (i + 1) + v.total));
    end
  endtask
  initial begin
    logic bad;
    vt[0] = '{16, 2, 32'h0, 32'h0, 32'h0, 4, '{0, 1, 2, 3}, '{0, 1, 0, 1}, '{1, 2, 8, 9}, 'b1010, 2, 16};
    vt[1] = '{20, 1, 32'h0, 32'h0, 32'h0, 3, '{0, 1, 2, 0}, '{0, 1, 2, 0}, '{1, 2, 3, 0}, 'b100, 1, 10};
    vt[2] = '{16, 1, 32'h1C, 32'h0, 32'h0, 2, '{0, 1, 0, 0}, '{0, 1, 0, 0}, '{1, 5, 0, 0}, 'b10, 1, 12};
    vt[3] = '{16, 1, 32'h0, 32'h0, 32'h0, 2, '{0, 1, 0, 0}, '{0, 1, 0, 0}, '{1, 2, 0, 0}, 'b10, 1, 9};
    vt[4] = '{0, 2, 32'h0, 32'h0, 32'h0, 0, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 0, 0, 2};
    vt[5] = '{16, 0, 32'h0, 32'h0, 32'h0, 0, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 0, 0, 2};
    vt[6] = vt[0];
    vt[6].start_m = 32'h0001_0008;
    vt[6].spur_m = 32'h0000_0202;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.total = 0;
    bus.no_of_rows = '0;
    bus.outsider_read_now = 1'b0;
    bus.dp_result = '0;
    bus.dp_result_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("reset outputs_zero", all_zero(), 1);
    reset = 1'b0;
    for (int i = 0; i < 7; i++) run(vt[i], $sformatf("vec%0d", i));
    @(negedge clk);
    bus.start = 1'b1;
    bus.total = 16;
    bus.no_of_rows = aw'(1);
    bus.outsider_read_now = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("abort busy_before_reset", bus.busy, 1);
    reset = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.start = 1'b0;
    bus.dp_result_valid = 1'b1;
    bus.dp_result = 32'h5555_5555;
    #1 chk("abort busy_after_reset", bus.busy, 0);
    bad = !all_zero();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.dp_result_valid = 1'b0;
      #1 if (!all_zero()) bad = 1'b1;
    end
    chk("abort outputs_stay_zero", bad, 0);
    run(vt[0], "after_abort");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mxv_row_sequencer.md
Name: mxv_row_sequencer

Overview:
- Controller that drives the dot-product datapath through a full matrix-vector product, one matrix row at a time.
- Streams each row of the matrix memory and the dense vector memory in no_of_units-element chunks into the dot-product unit.
- Waits for the unit's scalar result and writes it into the AP result memory at address = row index.
- Sits between the top-level solver FSM (start/done) and the dot-product engine plus its operand and result memories.

Parameters:
- element_width, 32, bits per element
- no_of_units, 8, elements per chunk (multiplier lanes in the dot-product unit)
- addr_width, 16, width of every memory address and of the row/element counts

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high; one clock; polarity and synchronicity fixed
- start  in  1  pulse; begins a product when in IDLE
- total  in  32  elements per row, sampled on accepted start
- no_of_rows  in  addr_width  rows to process, sampled on accepted start
- outsider_read_now  in  1  external permission to issue reads; low stalls chunk issue
- mat_rd_en  out  1  matrix memory read strobe
- mat_rd_addr  out  addr_width  chunk address, row*chunks_per_row + chunk
- vec_rd_en  out  1  vector memory read strobe, identical timing to mat_rd_en
- vec_rd_addr  out  addr_width  chunk index
- dp_in_valid  out  1  operands on the memory data buses are valid this cycle
- dp_last  out  1  with dp_in_valid: final chunk of the current row
- dp_result  in  element_width  dot-product result
- dp_result_valid  in  1  one-cycle pulse qualifying dp_result
- AP_total_mem_we  out  1  AP memory write enable
- ap_addr  out  addr_width  AP write address (row index)
- ap_data  out  element_width  AP write data
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last AP write

Behaviour:
- Reset: every output is 0, state is IDLE, all counters are 0. Reset mid-operation aborts immediately. No further reads or writes are issued, and a late dp_result_valid is ignored.
- chunks_per_row = ceil(total/no_of_units), computed once at start into a register.
- Memory read latency is fixed at 1 cycle. dp_in_valid and dp_last are the 1-cycle-delayed mat_rd_en and last-chunk flag.
- IDLE: on start, latch total, no_of_rows and chunks_per_row, then set busy=1.
  - If total==0 or no_of_rows==0: go to FINISH, with no reads and no writes.
  - Otherwise go to FETCH with row=0, chunk=0.
- FETCH: each cycle with outsider_read_now=1, assert both rd_en signals with the current addresses and increment chunk.
  - Cycles with outsider_read_now=0 issue nothing; chunk holds.
  - After issuing chunk chunks_per_row-1, go to WAIT_RES.
  - Reads are never issued outside FETCH.
- WAIT_RES: hold until dp_result_valid. Register dp_result and go to WRITE.
  - dp_result_valid outside WAIT_RES is ignored.
- WRITE: AP_total_mem_we=1 for exactly one cycle, with ap_addr=row and ap_data=the registered result.
  - If row==no_of_rows-1, go to FINISH.
  - Otherwise row+1, chunk=0, back to FETCH.
- FINISH: done=1 for one cycle, busy=0 on the next cycle, return to IDLE.
- start while busy is ignored. start in the same cycle as reset is ignored.
- Rows are strictly serialized: no row's reads start before the previous row's AP write.
- Address arithmetic: mat_rd_addr = row*chunks_per_row + chunk, truncated to addr_width; no overflow detection.
- Partial last chunk: the sequencer still reads a full chunk. Zero-padding of the tail in memory is the loader's responsibility.

Decomposition:
- Shared package (mxv_pkg): state enum {IDLE, FETCH, WAIT_RES, WRITE, FINISH}, element_width, no_of_units and addr_width defaults, and a ceil-divide function.
- One natural sub-module, mxv_chunk_addr_gen: holds the row/chunk counters and the base-address accumulator. It uses base += chunks_per_row per row, so no multiplier is needed.

Test Plan:
- total=16, rows=2, outsider_read_now=1, result returned 3 cycles after dp_last:
  - mat addresses 0,1 then 2,3; vec addresses 0,1,0,1.
  - dp_last on the 2nd and 4th dp_in_valid.
  - AP writes (0,R0), (1,R1); done one cycle after the second write.
- total=20, rows=1: chunks_per_row=3, addresses 0,1,2; exactly one AP write at addr 0.
- total=16, rows=1, outsider_read_now low on cycles 2-4 of FETCH:
  - issue gaps match the stall cycles; exactly 2 reads total.
  - result unchanged versus the unstalled run.
- total=0, or rows=0: no rd_en and no AP_total_mem_we; done pulses 2 cycles after start.
- Reset asserted in WAIT_RES, then a dp_result_valid pulse: no AP write, busy=0, all outputs 0. A new start then runs cleanly from row 0.
- Second start while busy and a spurious dp_result_valid during FETCH: both ignored; write count and values are identical to the clean run.
